// File: rtl/countdown_timer.sv
// countdown_timer
// Loads a minutes/seconds preset and counts down to 00:00.00 in 10 ms steps,
// one step per tick_10ms enable pulse. On reaching zero the timer parks in
// DONE, holds done high and pulses expired for one clock.
// All count/flag outputs come straight from registers; running and done are
// decodes of the state register.

module countdown_timer #(
  parameter logic [6:0] CTS_MAX  = 7'd99,
  parameter logic [5:0] SECS_MAX = 6'd59,
  parameter logic [6:0] MIN_MAX  = 7'd99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_10ms,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [6:0] min,
  output logic [5:0] sec,
  output logic [6:0] cs,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [6:0] min_r;
  logic [6:0] min_s;
  logic [5:0] sec_r;
  logic [5:0] sec_s;
  logic [6:0] cs_r;
  logic [6:0] cs_s;
  logic       expired_r;
  logic       expired_s;

  // Decremented count, computed once and used only when a tick is counted.
  logic [6:0] dec_min_s;
  logic [5:0] dec_sec_s;
  logic [6:0] dec_cs_s;

  // Saturate the minute preset to the largest displayable value.
  function automatic logic [6:0] clamp_min(input logic [6:0] value);
    if (value > MIN_MAX) begin
      clamp_min = MIN_MAX;
    end else begin
      clamp_min = value;
    end
  endfunction

  // Saturate the second preset so the display never shows 60..63.
  function automatic logic [5:0] clamp_sec(input logic [5:0] value);
    if (value > SECS_MAX) begin
      clamp_sec = SECS_MAX;
    end else begin
      clamp_sec = value;
    end
  endfunction

  // True when the whole count reads 00:00.00.
  function automatic logic count_is_zero(input logic [6:0] m,
                                         input logic [5:0] s,
                                         input logic [6:0] c);
    count_is_zero = (m == 7'd0) && (s == 6'd0) && (c == 7'd0);
  endfunction

  // One-step decrement with borrow chain cs -> sec -> min.
  always_comb begin
    dec_min_s = min_r;
    dec_sec_s = sec_r;
    dec_cs_s  = cs_r;
    if (cs_r != 7'd0) begin
      dec_cs_s = cs_r - 7'd1;
    end else begin
      dec_cs_s = CTS_MAX;
      if (sec_r != 6'd0) begin
        dec_sec_s = sec_r - 6'd1;
      end else begin
        dec_sec_s = SECS_MAX;
        // min is nonzero here: an all-zero count never reaches RUN.
        if (min_r != 7'd0) begin
          dec_min_s = min_r - 7'd1;
        end else begin
          dec_min_s = 7'd0;
        end
      end
    end
  end

  // Next-state and next-count logic; load wins over every other request.
  always_comb begin
    state_s   = state_r;
    min_s     = min_r;
    sec_s     = sec_r;
    cs_s      = cs_r;
    expired_s = 1'b0;
    if (load) begin
      // A tick arriving with load is dropped: the fresh preset stands.
      min_s   = clamp_min(preset_min);
      sec_s   = clamp_sec(preset_sec);
      cs_s    = 7'd0;
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // Starting from zero would expire instantly, so it is refused.
          if (start && !count_is_zero(min_r, sec_r, cs_r)) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (pause) begin
            // Freeze immediately; a simultaneous tick is not counted.
            state_s = PAUSE;
          end else if (count_is_zero(min_r, sec_r, cs_r)) begin
            // Defensive: a zero count in RUN is parked without a pulse.
            state_s = DONE;
          end else if (tick_10ms) begin
            min_s = dec_min_s;
            sec_s = dec_sec_s;
            cs_s  = dec_cs_s;
            if (count_is_zero(dec_min_s, dec_sec_s, dec_cs_s)) begin
              state_s   = DONE;
              expired_s = 1'b1;
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = RUN;
          end
        end
        PAUSE: begin
          // Ticks are ignored; the first decrement follows the resume.
          if (start) begin
            state_s = RUN;
          end else begin
            state_s = PAUSE;
          end
        end
        DONE: begin
          // Only load or reset leave DONE; the count stays at zero.
          state_s = DONE;
          min_s   = 7'd0;
          sec_s   = 6'd0;
          cs_s    = 7'd0;
        end
        default: begin
          // Unreachable encoding: recover to a clean idle zero count.
          state_s = IDLE;
          min_s   = 7'd0;
          sec_s   = 6'd0;
          cs_s    = 7'd0;
        end
      endcase
    end
  end

  // State, count and expired registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      min_r     <= 7'd0;
      sec_r     <= 6'd0;
      cs_r      <= 7'd0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      min_r     <= min_s;
      sec_r     <= sec_s;
      cs_r      <= cs_s;
      expired_r <= expired_s;
    end
  end

  assign min     = min_r;
  assign sec     = sec_r;
  assign cs      = cs_r;
  assign expired = expired_r;
  assign running = (state_r == RUN);
  assign done    = (state_r == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
// Directed scenarios plus a randomized phase, checked every clock against a
// reference model that keeps the remaining time as a single centisecond total.

module tb_countdown_timer;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk;
  logic       rst;
  logic       tick_10ms;
  logic       load;
  logic       start;
  logic       pause;
  logic [6:0] preset_min;
  logic [5:0] preset_sec;
  logic [6:0] min;
  logic [5:0] sec;
  logic [6:0] cs;
  logic       running;
  logic       done;
  logic       expired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining time in centiseconds and a coarse mode.
  int rem_cs   = 0;
  int mode     = M_IDLE;
  int exp_puls = 0;

  int exp_seen;
  int exp_at;

  countdown_timer dut (
    .clk       (clk),
    .rst       (rst),
    .tick_10ms (tick_10ms),
    .load      (load),
    .start     (start),
    .pause     (pause),
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .min       (min),
    .sec       (sec),
    .cs        (cs),
    .running   (running),
    .done      (done),
    .expired   (expired)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input int obs, input int expd);
    n_checks++;
    if (obs != expd) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expd, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, "_min"}, int'(min), rem_cs / 6000);
    check_value({tag, "_sec"}, int'(sec), (rem_cs / 100) % 60);
    check_value({tag, "_cs"}, int'(cs), rem_cs % 100);
    check_value({tag, "_running"}, int'(running), (mode == M_RUN) ? 1 : 0);
    check_value({tag, "_done"}, int'(done), (mode == M_DONE) ? 1 : 0);
    check_value({tag, "_expired"}, int'(expired), exp_puls);
  endtask

  // Apply one clock of inputs, advance the model, then check after the edge.
  task automatic step(input bit ld, input bit st, input bit ps, input bit tk,
                      input int pm, input int psec, input string tag);
    int cm;
    int csx;
    load       = ld;
    start      = st;
    pause      = ps;
    tick_10ms  = tk;
    preset_min = 7'(pm);
    preset_sec = 6'(psec);
    @(posedge clk);
    exp_puls = 0;
    if (ld) begin
      cm     = (pm > 99) ? 99 : pm;
      csx    = (psec > 59) ? 59 : psec;
      rem_cs = (cm * 60 + csx) * 100;
      mode   = M_IDLE;
    end else if (mode == M_IDLE) begin
      if (st && rem_cs != 0) mode = M_RUN;
    end else if (mode == M_RUN) begin
      if (ps) begin
        mode = M_PAUSE;
      end else if (tk) begin
        rem_cs--;
        if (rem_cs == 0) begin
          mode     = M_DONE;
          exp_puls = 1;
        end
      end
    end else if (mode == M_PAUSE) begin
      if (st) mode = M_RUN;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_step(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, tag);
  endtask

  task automatic tick_step(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, tag);
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0; start = 1'b0; pause = 1'b0; tick_10ms = 1'b0;
    preset_min = 7'd0; preset_sec = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    idle_step("post_reset");

    // 1: 00:02 runs for exactly 200 ticks, one expired pulse at tick 200.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 2, "t1_load");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t1_start");
    exp_seen = 0;
    exp_at   = 0;
    for (int i = 1; i <= 200; i++) begin
      tick_step("t1_tick");
      if (i == 1) check_value("t1_first_cs", int'(cs), 99);
      if (expired) begin
        exp_seen++;
        exp_at = i;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, "t1_done_hold");
      if (expired) exp_seen++;
    end
    check_value("t1_expired_count", exp_seen, 1);
    check_value("t1_expired_tick", exp_at, 200);
    check_value("t1_done", int'(done), 1);

    // 2: borrow through seconds into minutes.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1, 0, "t2_load");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t2_start");
    tick_step("t2_tick1");
    check_value("t2_min1", int'(min), 0);
    check_value("t2_sec1", int'(sec), 59);
    check_value("t2_cs1", int'(cs), 99);
    tick_step("t2_tick2");
    check_value("t2_cs2", int'(cs), 98);

    // 3: pause freezes at 00:00.70, resume needs a fresh tick.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, "t3_load");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t3_start");
    for (int i = 0; i < 30; i++) tick_step("t3_run_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, "t3_pause");
    check_value("t3_frozen_cs", int'(cs), 70);
    for (int i = 0; i < 50; i++) tick_step("t3_paused");
    check_value("t3_still_cs", int'(cs), 70);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, "t3_resume");
    check_value("t3_resume_cs", int'(cs), 70);
    for (int i = 0; i < 69; i++) tick_step("t3_run_b");
    check_value("t3_not_done", int'(done), 0);
    tick_step("t3_last");
    check_value("t3_expired", int'(expired), 1);

    // 4: zero preset refuses to start.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "t4_load");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t4_start");
    for (int i = 0; i < 5; i++) tick_step("t4_tick");
    check_value("t4_running", int'(running), 0);

    // 5: preset saturation, and load beats a simultaneous tick.
    step(1'b1, 1'b0, 1'b0, 1'b0, 120, 63, "t5_load");
    check_value("t5_min", int'(min), 99);
    check_value("t5_sec", int'(sec), 59);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t5_start");
    tick_step("t5_tick");
    step(1'b1, 1'b0, 1'b0, 1'b1, 3, 7, "t5_load_tick");
    check_value("t5_lt_cs", int'(cs), 0);
    check_value("t5_lt_sec", int'(sec), 7);

    // 6: asynchronous reset mid-run, then start is refused.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1, "t6_load");
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, "t6_start");
    for (int i = 0; i < 50; i++) tick_step("t6_run");
    check_value("t6_cs50", int'(cs), 50);
    #2;
    rst = 1'b0;
    rem_cs = 0; mode = M_IDLE; exp_puls = 0;
    #1;
    check_outputs("t6_in_reset");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, "t6_start_zero");

    // Randomized phase: short presets so countdowns complete often.
    for (int i = 0; i < 4000; i++) begin
      bit ld, st, ps, tk;
      int pm, psec;
      ld = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 19) == 0) && (mode != M_RUN);
      ps = ($urandom_range(0, 29) == 0);
      tk = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) begin
        pm   = 0;
        psec = $urandom_range(0, 2);
      end else begin
        pm   = $urandom_range(0, 127);
        psec = $urandom_range(0, 63);
      end
      step(ld, st, ps, tk, pm, psec, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
